// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory responder: I/O window offsets,
// STATUS bit positions and the byte-address decoder.
package cpu_mem_pkg;

    localparam logic [7:0] IO_LED    = 8'h00;
    localparam logic [7:0] IO_CYCLE  = 8'h02;
    localparam logic [7:0] IO_TIMER  = 8'h04;
    localparam logic [7:0] IO_STATUS = 8'h06;

    localparam int STAT_EXPIRED = 0;
    localparam int STAT_ERR     = 1;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_IO,
        REG_OOR
    } region_t;

    // The I/O page wins over RAM; anything else maps to a RAM word index
    // (byte address >> 1) that is either inside the array or out of range.
    function automatic region_t decode_addr(input logic [15:0] addr,
                                            input logic [7:0]  io_page,
                                            input int unsigned mem_words);
        logic [15:0] word_idx;
        region_t     region;
        word_idx = addr >> 1;
        if (addr[15:8] == io_page) begin
            region = REG_IO;
        end else if (32'(word_idx) >= mem_words) begin
            region = REG_OOR;
        end else begin
            region = REG_RAM;
        end
        return region;
    endfunction

endpackage

// File: rtl/cpu_mem_io.sv
// Memory-mapped I/O registers: LED latch, free-running cycle counter,
// countdown timer with sticky expiry, and the sticky access-error flag.
// Read data is combinational so the parent can register it alongside RAM.
module cpu_mem_io
    import cpu_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        wr_en_i,
    input  logic [7:0]  wr_off_i,
    input  logic [15:0] wr_data_i,
    input  logic [7:0]  rd_off_i,
    input  logic        err_set_i,
    output logic [15:0] rd_data_o,
    output logic [15:0] leds_o,
    output logic        err_o
);

    logic [15:0] led_q, led_d;
    logic [15:0] cycle_q, cycle_d;
    logic [15:0] timer_q, timer_d;
    logic        expired_q, expired_d;
    logic        err_q, err_d;

    logic wr_led, wr_timer, wr_status;

    assign wr_led    = wr_en_i && (wr_off_i == IO_LED);
    assign wr_timer  = wr_en_i && (wr_off_i == IO_TIMER);
    assign wr_status = wr_en_i && (wr_off_i == IO_STATUS);

    // Next-state for all I/O registers; sets are applied after clears so
    // a new event on the same edge as a clear is never lost.
    always_comb begin
        led_d     = wr_led ? wr_data_i : led_q;
        cycle_d   = cycle_q + 16'd1;
        timer_d   = timer_q;
        expired_d = expired_q;
        err_d     = err_q;

        if (wr_timer) begin
            timer_d = wr_data_i;
        end else if (timer_q != 16'd0) begin
            timer_d = timer_q - 16'd1;
        end

        if (wr_status && wr_data_i[STAT_EXPIRED]) begin
            expired_d = 1'b0;
        end
        // Only a decrement from 1 expires the timer; a direct write of 0 does not.
        if (!wr_timer && (timer_q == 16'd1)) begin
            expired_d = 1'b1;
        end

        if (wr_status && wr_data_i[STAT_ERR]) begin
            err_d = 1'b0;
        end
        if (err_set_i) begin
            err_d = 1'b1;
        end
    end

    // I/O state register.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            led_q     <= '0;
            cycle_q   <= '0;
            timer_q   <= '0;
            expired_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            led_q     <= led_d;
            cycle_q   <= cycle_d;
            timer_q   <= timer_d;
            expired_q <= expired_d;
            err_q     <= err_d;
        end
    end

    // Read mux; unmapped offsets read as zero.
    always_comb begin
        rd_data_o = '0;
        case (rd_off_i)
            IO_LED:    rd_data_o = led_q;
            IO_CYCLE:  rd_data_o = cycle_q;
            IO_TIMER:  rd_data_o = timer_q;
            IO_STATUS: begin
                rd_data_o[STAT_EXPIRED] = expired_q;
                rd_data_o[STAT_ERR]     = err_q;
            end
            default:   rd_data_o = '0;
        endcase
    end

    assign leds_o = led_q;
    assign err_o  = err_q;

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU fetch and load/store ports. One unified
// RAM of 16-bit words answers both ports with one registered cycle of
// latency; the top byte page IO_BASE is steered to the I/O register block.
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [15:0] IO_BASE   = 16'hFF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_pc_addr,
    input  logic        i_pc_rd,
    output logic [15:0] o_pc_rddata,
    input  logic [15:0] i_ldst_addr,
    input  logic        i_ldst_rd,
    input  logic        i_ldst_wr,
    input  logic [15:0] i_ldst_wrdata,
    output logic [15:0] o_ldst_rddata,
    input  logic        i_load_en,
    input  logic [15:0] i_load_addr,
    input  logic [15:0] i_load_data,
    output logic [15:0] o_leds,
    output logic        o_err
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [15:0] mem [MEM_WORDS];

    region_t     pc_region, ls_region;
    logic [AW-1:0] pc_idx, ls_idx;
    logic [7:0]  ls_off;
    logic        store_ok, ram_we, io_we, load_ok, err_set;
    logic [15:0] io_rdata;
    logic [15:0] pc_rddata_q, pc_rddata_d;
    logic [15:0] ldst_rddata_q, ldst_rddata_d;

    assign pc_region = decode_addr(i_pc_addr, IO_BASE[15:8], MEM_WORDS);
    assign ls_region = decode_addr(i_ldst_addr, IO_BASE[15:8], MEM_WORDS);
    assign pc_idx    = i_pc_addr[AW:1];
    assign ls_idx    = i_ldst_addr[AW:1];
    assign ls_off    = {i_ldst_addr[7:1], 1'b0};

    // A preload in the same cycle drops the store wherever it was headed;
    // stores presented while reset is held are dropped too.
    assign store_ok = reset && i_ldst_wr && !i_load_en;
    assign ram_we   = store_ok && (ls_region == REG_RAM);
    assign io_we    = store_ok && (ls_region == REG_IO);
    assign load_ok  = i_load_en && (32'(i_load_addr) < MEM_WORDS);

    assign err_set = (i_pc_rd   && (pc_region != REG_RAM))
                   || (i_ldst_rd && (ls_region == REG_OOR))
                   || (store_ok  && (ls_region == REG_OOR));

    // RAM write port shared by preload and load/store; preload has priority.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[i_load_addr[AW-1:0]] <= i_load_data;
        end else if (ram_we) begin
            mem[ls_idx] <= i_ldst_wrdata;
        end
    end

    // Fetch read data: write-first bypass from a same-edge store to the same word.
    always_comb begin
        pc_rddata_d = pc_rddata_q;
        if (i_pc_rd) begin
            if (pc_region == REG_RAM) begin
                pc_rddata_d = (ram_we && (ls_idx == pc_idx)) ? i_ldst_wrdata : mem[pc_idx];
            end else begin
                pc_rddata_d = '0;
            end
        end
    end

    // Load read data: a combined read+write returns the value being written.
    always_comb begin
        ldst_rddata_d = ldst_rddata_q;
        if (i_ldst_rd) begin
            case (ls_region)
                REG_RAM: ldst_rddata_d = ram_we ? i_ldst_wrdata : mem[ls_idx];
                REG_IO:  ldst_rddata_d = io_we  ? i_ldst_wrdata : io_rdata;
                default: ldst_rddata_d = '0;
            endcase
        end
    end

    // Read data registers for both ports.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_rddata_q   <= '0;
            ldst_rddata_q <= '0;
        end else begin
            pc_rddata_q   <= pc_rddata_d;
            ldst_rddata_q <= ldst_rddata_d;
        end
    end

    cpu_mem_io u_io (
        .clk       (clk),
        .rst_ni    (reset),
        .wr_en_i   (io_we),
        .wr_off_i  (ls_off),
        .wr_data_i (i_ldst_wrdata),
        .rd_off_i  (ls_off),
        .err_set_i (err_set),
        .rd_data_o (io_rdata),
        .leds_o    (o_leds),
        .err_o     (o_err)
    );

    assign o_pc_rddata   = pc_rddata_q;
    assign o_ldst_rddata = ldst_rddata_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder with the default parameters.
// A word-array model of the RAM plus simple arithmetic for the timer and
// counter provide every expected value.
module tb_cpu_mem_responder;

    localparam int unsigned MEM_WORDS = 256;
    localparam logic [15:0] IO_BASE   = 16'hFF00;
    localparam logic [15:0] A_LED     = IO_BASE + 16'h0000;
    localparam logic [15:0] A_CYCLE   = IO_BASE + 16'h0002;
    localparam logic [15:0] A_TIMER   = IO_BASE + 16'h0004;
    localparam logic [15:0] A_STATUS  = IO_BASE + 16'h0006;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] i_pc_addr = '0;
    logic        i_pc_rd = 1'b0;
    logic [15:0] o_pc_rddata;
    logic [15:0] i_ldst_addr = '0;
    logic        i_ldst_rd = 1'b0;
    logic        i_ldst_wr = 1'b0;
    logic [15:0] i_ldst_wrdata = '0;
    logic [15:0] o_ldst_rddata;
    logic        i_load_en = 1'b0;
    logic [15:0] i_load_addr = '0;
    logic [15:0] i_load_data = '0;
    logic [15:0] o_leds;
    logic        o_err;

    int total = 0;
    int bad   = 0;

    logic [15:0] model_mem [MEM_WORDS];

    always #5 clk = ~clk;

    cpu_mem_responder #(.MEM_WORDS(MEM_WORDS), .IO_BASE(IO_BASE)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_pc_addr     (i_pc_addr),
        .i_pc_rd       (i_pc_rd),
        .o_pc_rddata   (o_pc_rddata),
        .i_ldst_addr   (i_ldst_addr),
        .i_ldst_rd     (i_ldst_rd),
        .i_ldst_wr     (i_ldst_wr),
        .i_ldst_wrdata (i_ldst_wrdata),
        .o_ldst_rddata (o_ldst_rddata),
        .i_load_en     (i_load_en),
        .i_load_addr   (i_load_addr),
        .i_load_data   (i_load_data),
        .o_leds        (o_leds),
        .o_err         (o_err)
    );

    // Inputs change 1 time unit after a rising edge and outputs are sampled there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_ram(input logic [15:0] addr);
        return (addr[15:8] != IO_BASE[15:8]) && (32'(addr[15:1]) < MEM_WORDS);
    endfunction

    task automatic preload(input logic [15:0] idx, input logic [15:0] data);
        i_load_en = 1'b1; i_load_addr = idx; i_load_data = data;
        tick();
        i_load_en = 1'b0;
        if (32'(idx) < MEM_WORDS) model_mem[idx[7:0]] = data;
    endtask

    task automatic store(input logic [15:0] addr, input logic [15:0] data);
        i_ldst_wr = 1'b1; i_ldst_addr = addr; i_ldst_wrdata = data;
        tick();
        i_ldst_wr = 1'b0;
        if (is_ram(addr)) model_mem[addr[8:1]] = data;
        $display("store addr=%h data=%h", addr, data);
    endtask

    task automatic ld_read(input logic [15:0] addr);
        i_ldst_rd = 1'b1; i_ldst_addr = addr;
        tick();
        i_ldst_rd = 1'b0;
        $display("load  addr=%h data=%h err=%b", addr, o_ldst_rddata, o_err);
    endtask

    task automatic pc_read(input logic [15:0] addr);
        i_pc_rd = 1'b1; i_pc_addr = addr;
        tick();
        i_pc_rd = 1'b0;
        $display("fetch addr=%h data=%h err=%b", addr, o_pc_rddata, o_err);
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        total++; if (o_pc_rddata !== 16'h0) begin bad++; $display("FAIL reset_pc got=%h want=0000", o_pc_rddata); end
        total++; if (o_ldst_rddata !== 16'h0) begin bad++; $display("FAIL reset_ldst got=%h want=0000", o_ldst_rddata); end
        total++; if (o_leds !== 16'h0) begin bad++; $display("FAIL reset_leds got=%h want=0000", o_leds); end
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", o_err); end
        // Fill the RAM with random words while reset is held.
        for (int i = 0; i < int'(MEM_WORDS); i++) preload(16'(i), 16'($urandom));
        reset = 1'b1;
        // First strobe edge after release sees the counter still at zero.
        ld_read(A_CYCLE);
        total++; if (o_ldst_rddata !== 16'h0) begin bad++; $display("FAIL cycle_after_reset got=%h want=0000", o_ldst_rddata); end
    endtask

    task automatic test_fetch();
        logic [15:0] a;
        preload(16'd0, 16'h1111); preload(16'd1, 16'h2222);
        preload(16'd2, 16'h3333); preload(16'd3, 16'h4444);
        i_pc_rd = 1'b1; i_pc_addr = 16'h0000;
        tick();
        total++; if (o_pc_rddata !== 16'h1111) begin bad++; $display("FAIL fetch0 got=%h want=1111", o_pc_rddata); end
        i_pc_addr = 16'h0002;
        tick();
        total++; if (o_pc_rddata !== 16'h2222) begin bad++; $display("FAIL fetch2 got=%h want=2222", o_pc_rddata); end
        i_pc_addr = 16'h0006;
        tick();
        total++; if (o_pc_rddata !== 16'h4444) begin bad++; $display("FAIL fetch6 got=%h want=4444", o_pc_rddata); end
        i_pc_rd = 1'b0; i_pc_addr = 16'h0002;
        tick();
        total++; if (o_pc_rddata !== 16'h4444) begin bad++; $display("FAIL fetch_hold got=%h want=4444", o_pc_rddata); end
        for (int n = 0; n < 16; n++) begin
            a = 16'($urandom_range(0, MEM_WORDS - 1));
            pc_read({a[14:0], 1'($urandom)});
            total++; if (o_pc_rddata !== model_mem[a[7:0]]) begin bad++; $display("FAIL fetch_rand idx=%0d got=%h want=%h", a, o_pc_rddata, model_mem[a[7:0]]); end
        end
    endtask

    task automatic test_write_first();
        i_ldst_wr = 1'b1; i_ldst_addr = 16'h0010; i_ldst_wrdata = 16'hBEEF;
        i_pc_rd = 1'b1; i_pc_addr = 16'h0010;
        tick();
        i_ldst_wr = 1'b0; i_pc_rd = 1'b0;
        model_mem[8] = 16'hBEEF;
        total++; if (o_pc_rddata !== 16'hBEEF) begin bad++; $display("FAIL wf_pc got=%h want=beef", o_pc_rddata); end
        ld_read(16'h0010);
        total++; if (o_ldst_rddata !== 16'hBEEF) begin bad++; $display("FAIL wf_ldst got=%h want=beef", o_ldst_rddata); end
    endtask

    task automatic test_ldst_random();
        logic [15:0] idx, data;
        int op;
        for (int n = 0; n < 40; n++) begin
            op   = int'($urandom_range(0, 2));
            idx  = 16'($urandom_range(0, MEM_WORDS - 1));
            data = 16'($urandom);
            if (op == 0) begin
                store({idx[14:0], 1'b0}, data);
            end else if (op == 1) begin
                ld_read({idx[14:0], 1'($urandom)});
                total++; if (o_ldst_rddata !== model_mem[idx[7:0]]) begin bad++; $display("FAIL ld_rand idx=%0d got=%h want=%h", idx, o_ldst_rddata, model_mem[idx[7:0]]); end
            end else begin
                i_ldst_rd = 1'b1; i_ldst_wr = 1'b1;
                i_ldst_addr = {idx[14:0], 1'b0}; i_ldst_wrdata = data;
                tick();
                i_ldst_rd = 1'b0; i_ldst_wr = 1'b0;
                model_mem[idx[7:0]] = data;
                $display("rdwr  addr=%h data=%h", i_ldst_addr, o_ldst_rddata);
                total++; if (o_ldst_rddata !== data) begin bad++; $display("FAIL rdwr idx=%0d got=%h want=%h", idx, o_ldst_rddata, data); end
            end
        end
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL ld_rand_err got=%b want=0", o_err); end
    endtask

    task automatic test_preload_priority();
        logic [15:0] a, b, x, y;
        a = 16'($urandom_range(100, 127));
        b = 16'($urandom_range(128, 200));
        x = 16'($urandom); y = ~model_mem[b[7:0]];
        i_load_en = 1'b1; i_load_addr = a; i_load_data = x;
        i_ldst_wr = 1'b1; i_ldst_addr = {b[14:0], 1'b0}; i_ldst_wrdata = y;
        tick();
        i_load_en = 1'b0; i_ldst_wr = 1'b0;
        model_mem[a[7:0]] = x;
        ld_read({a[14:0], 1'b0});
        total++; if (o_ldst_rddata !== x) begin bad++; $display("FAIL preload_win got=%h want=%h", o_ldst_rddata, x); end
        ld_read({b[14:0], 1'b0});
        total++; if (o_ldst_rddata !== model_mem[b[7:0]]) begin bad++; $display("FAIL store_dropped got=%h want=%h", o_ldst_rddata, model_mem[b[7:0]]); end
        preload(16'(MEM_WORDS + 5), 16'hDEAD);
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL preload_oor_err got=%b want=0", o_err); end
        ld_read(16'h000A);
        total++; if (o_ldst_rddata !== model_mem[5]) begin bad++; $display("FAIL preload_oor_alias got=%h want=%h", o_ldst_rddata, model_mem[5]); end
    endtask

    task automatic test_led_cycle();
        logic [15:0] c0, diff;
        store(A_LED, 16'h00A5);
        total++; if (o_leds !== 16'h00A5) begin bad++; $display("FAIL leds got=%h want=00a5", o_leds); end
        ld_read(A_LED);
        total++; if (o_ldst_rddata !== 16'h00A5) begin bad++; $display("FAIL led_read got=%h want=00a5", o_ldst_rddata); end
        ld_read(A_CYCLE);
        c0 = o_ldst_rddata;
        repeat (4) tick();
        ld_read(A_CYCLE);
        diff = o_ldst_rddata - c0;
        total++; if (diff !== 16'd5) begin bad++; $display("FAIL cycle_diff got=%0d want=5", diff); end
        ld_read(A_CYCLE);
        c0 = o_ldst_rddata;
        repeat (65535) tick();
        ld_read(A_CYCLE);
        total++; if (o_ldst_rddata !== c0) begin bad++; $display("FAIL cycle_wrap got=%h want=%h", o_ldst_rddata, c0); end
    endtask

    task automatic test_timer();
        int t;
        logic [15:0] exp;
        // Countdown: the read strobed k edges after the write sees max(t-(k-1), 0).
        for (int rep = 0; rep < 2; rep++) begin
            t = (rep == 0) ? 3 : int'($urandom_range(2, 9));
            store(A_TIMER, 16'(t));
            i_ldst_rd = 1'b1; i_ldst_addr = A_TIMER;
            for (int k = 1; k <= t + 2; k++) begin
                tick();
                exp = (k - 1 >= t) ? 16'd0 : 16'(t - (k - 1));
                total++; if (o_ldst_rddata !== exp) begin bad++; $display("FAIL timer t=%0d k=%0d got=%h want=%h", t, k, o_ldst_rddata, exp); end
            end
            i_ldst_rd = 1'b0;
        end
        ld_read(A_STATUS);
        total++; if (o_ldst_rddata !== 16'h0001) begin bad++; $display("FAIL expired_set got=%h want=0001", o_ldst_rddata); end
        store(A_STATUS, 16'h0001);
        ld_read(A_STATUS);
        total++; if (o_ldst_rddata !== 16'h0000) begin bad++; $display("FAIL expired_clear got=%h want=0000", o_ldst_rddata); end
        // Expiry edge: sampled status shows bit0 only for strobes after the 1->0 edge.
        t = int'($urandom_range(2, 6));
        store(A_TIMER, 16'(t));
        i_ldst_rd = 1'b1; i_ldst_addr = A_STATUS;
        for (int k = 1; k <= t + 2; k++) begin
            tick();
            exp = (k > t) ? 16'h0001 : 16'h0000;
            total++; if (o_ldst_rddata !== exp) begin bad++; $display("FAIL expiry_edge t=%0d k=%0d got=%h want=%h", t, k, o_ldst_rddata, exp); end
        end
        i_ldst_rd = 1'b0;
        store(A_STATUS, 16'h0001);
        store(A_TIMER, 16'h0000);
        repeat (3) tick();
        ld_read(A_STATUS);
        total++; if (o_ldst_rddata !== 16'h0000) begin bad++; $display("FAIL timer_zero_write got=%h want=0000", o_ldst_rddata); end
    endtask

    task automatic test_err();
        ld_read(16'h0200);
        total++; if (o_ldst_rddata !== 16'h0000) begin bad++; $display("FAIL oor_read got=%h want=0000", o_ldst_rddata); end
        total++; if (o_err !== 1'b1) begin bad++; $display("FAIL oor_read_err got=%b want=1", o_err); end
        pc_read(IO_BASE);
        total++; if (o_pc_rddata !== 16'h0000) begin bad++; $display("FAIL io_fetch got=%h want=0000", o_pc_rddata); end
        total++; if (o_err !== 1'b1) begin bad++; $display("FAIL io_fetch_err got=%b want=1", o_err); end
        ld_read(A_STATUS);
        total++; if (o_ldst_rddata !== 16'h0002) begin bad++; $display("FAIL status_err got=%h want=0002", o_ldst_rddata); end
        store(A_STATUS, 16'h0002);
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", o_err); end
        store(16'h0200, 16'h5A5A);
        total++; if (o_err !== 1'b1) begin bad++; $display("FAIL oor_write_err got=%b want=1", o_err); end
        ld_read(16'h0000);
        total++; if (o_ldst_rddata !== model_mem[0]) begin bad++; $display("FAIL oor_write_dropped got=%h want=%h", o_ldst_rddata, model_mem[0]); end
        // Clear and a fresh error on the same edge: the error survives.
        i_ldst_wr = 1'b1; i_ldst_addr = A_STATUS; i_ldst_wrdata = 16'h0002;
        i_pc_rd = 1'b1; i_pc_addr = IO_BASE;
        tick();
        i_ldst_wr = 1'b0; i_pc_rd = 1'b0;
        total++; if (o_err !== 1'b1) begin bad++; $display("FAIL err_set_wins got=%b want=1", o_err); end
        store(A_STATUS, 16'h0002);
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL err_clear2 got=%b want=0", o_err); end
    endtask

    task automatic test_reset_mid();
        store(A_LED, 16'h00A5);
        store(A_TIMER, 16'h0007);
        pc_read(16'h0200);
        pc_read(16'h0002);
        ld_read(16'h0004);
        reset = 1'b0;
        #1;
        total++; if (o_leds !== 16'h0) begin bad++; $display("FAIL mid_reset_leds got=%h want=0000", o_leds); end
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL mid_reset_err got=%b want=0", o_err); end
        total++; if (o_pc_rddata !== 16'h0) begin bad++; $display("FAIL mid_reset_pc got=%h want=0000", o_pc_rddata); end
        total++; if (o_ldst_rddata !== 16'h0) begin bad++; $display("FAIL mid_reset_ldst got=%h want=0000", o_ldst_rddata); end
        tick();
        reset = 1'b1;
        ld_read(A_TIMER);
        total++; if (o_ldst_rddata !== 16'h0) begin bad++; $display("FAIL mid_reset_timer got=%h want=0000", o_ldst_rddata); end
        ld_read(A_STATUS);
        total++; if (o_ldst_rddata !== 16'h0) begin bad++; $display("FAIL mid_reset_status got=%h want=0000", o_ldst_rddata); end
        ld_read(16'h0006);
        total++; if (o_ldst_rddata !== model_mem[3]) begin bad++; $display("FAIL ram_kept got=%h want=%h", o_ldst_rddata, model_mem[3]); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_write_first();
        test_ldst_random();
        test_preload_priority();
        test_led_cycle();
        test_timer();
        test_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
